// File: rtl/pipe_reg_fifo.sv
// pipe_reg_fifo: DEPTH-entry show-ahead pipeline buffer with valid/ready on both sides and hold/flush control.
// Optional zero-latency bypass of an empty buffer is enabled by defining PIPE_REG_FIFO_BYPASS_EN.
module pipe_reg_fifo #(
   parameter int unsigned      WIDTH       = 32,
   parameter int unsigned      DEPTH       = 2,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0,
   parameter logic [7:0]       FLUSH_CODES = 8'b0000_1010,
   parameter logic [7:0]       HOLD_CODES  = 8'b0001_0100
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2:0]                 hold_flag,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           din,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("pipe_reg_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             flush_c;
   logic             hold_c;
   logic             run_c;
   logic             empty_c;
   logic             full_c;
   logic             byp_c;
   logic             push_c;
   logic             pop_c;
   logic             wr_en_c;
   logic             rd_en_c;
   logic [WIDTH-1:0] head_c;

   // Control decode: flush outranks hold when a code appears in both masks.
   always_comb begin
      flush_c = FLUSH_CODES[hold_flag];
      hold_c  = HOLD_CODES[hold_flag] & ~flush_c;
      run_c   = ~flush_c & ~hold_c;
      empty_c = (count_q == '0);
      full_c  = (count_q == CNT_W'(DEPTH));
      head_c  = empty_c ? RESET_VAL : mem_q[rd_ptr_q];
`ifdef PIPE_REG_FIFO_BYPASS_EN
      byp_c   = run_c & empty_c & in_valid;
`else
      byp_c   = 1'b0;
`endif
   end

   // Handshake outputs; a bypassed beat taken by downstream is never stored.
   always_comb begin
      in_ready  = run_c & ~full_c;
      out_valid = (run_c & ~empty_c) | byp_c;
      dout      = byp_c ? din : head_c;
      count     = count_q;
      push_c    = in_valid & in_ready;
      pop_c     = out_valid & out_ready;
      wr_en_c   = push_c & ~(byp_c & out_ready);
      rd_en_c   = pop_c & ~empty_c;
   end

   // Next-state pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_c) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else if (run_c) begin
         if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (rd_en_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (wr_en_c && !rd_en_c) begin
            count_d = count_q + CNT_W'(1);
         end else if (!wr_en_c && rd_en_c) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; only occupancy decides what is visible.
   always_ff @(posedge clk) begin
      if (rst && wr_en_c) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: tb/tb_pipe_reg_fifo.sv
// Scoreboard bench for pipe_reg_fifo: directed scenarios then random traffic against a queue model.
module tb_pipe_reg_fifo;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 2;
   localparam logic [WIDTH-1:0] RESET_VAL = 32'h0;
   localparam logic [7:0] FLUSH_CODES = 8'b0000_1010;
   localparam logic [7:0] HOLD_CODES  = 8'b0001_0100;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [2:0]       hold_flag = 3'd0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] din = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] dout;
   logic [1:0]       count;

   int checks = 0;
   int failures = 0;

   pipe_reg_fifo #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RESET_VAL),
      .FLUSH_CODES(FLUSH_CODES), .HOLD_CODES(HOLD_CODES)
   ) dut (
      .clk(clk), .rst(rst), .hold_flag(hold_flag),
      .in_valid(in_valid), .in_ready(in_ready), .din(din),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // Reference model: expected buffer contents, oldest first.
   logic [WIDTH-1:0] model[$];
   logic             armed = 1'b0;
   logic             m_fl, m_act, m_ir, m_ov, m_byp;
   logic [WIDTH-1:0] m_dout, m_got;
   int               m_n;

   always @(negedge clk) begin
      if (!rst) begin
         model.delete();
         armed = 1'b1;
      end else if (armed) begin
         m_n    = model.size();
         m_fl   = FLUSH_CODES[hold_flag];
         m_act  = !m_fl && !HOLD_CODES[hold_flag];
         m_ir   = m_act && (m_n != DEPTH);
         m_ov   = m_act && (m_n != 0);
         m_dout = (m_n != 0) ? model[0] : RESET_VAL;
         m_byp  = 1'b0;
`ifdef PIPE_REG_FIFO_BYPASS_EN
         if (m_act && m_n == 0 && in_valid) begin
            m_byp  = 1'b1;
            m_ov   = 1'b1;
            m_dout = din;
         end
`endif
         chk("count", 32'(count), 32'(m_n));
         chk("in_ready", 32'(in_ready), 32'(m_ir));
         chk("out_valid", 32'(out_valid), 32'(m_ov));
         if (m_fl) begin
            model.delete();
         end else if (m_act) begin
            if (m_ov && out_ready) begin
               if (m_byp) begin
                  chk("bypass_data", dout, din);
               end else begin
                  m_got = model.pop_front();
                  chk("pop_data", dout, m_got);
               end
            end else begin
               chk("dout", dout, m_dout);
            end
            if (in_valid && m_ir && !(m_byp && out_ready)) model.push_back(din);
         end else begin
            chk("dout_hold", dout, m_dout);
         end
      end
   end

   task automatic drive(input logic [2:0] hf, input logic iv, input logic [31:0] d, input logic ordy);
      @(posedge clk);
      #1;
      hold_flag = hf;
      in_valid  = iv;
      din       = d;
      out_ready = ordy;
   endtask

   initial begin
      // Reset with a stray push pending
      rst = 1'b0;
      in_valid = 1'b1;
      din = 32'hDEAD;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_dout", dout, RESET_VAL);
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      // Fill then drain
      drive(3'd0, 1'b1, 32'hA1, 1'b0);
      drive(3'd0, 1'b1, 32'hB2, 1'b0);
      drive(3'd0, 1'b0, 32'h0, 1'b0);
      repeat (3) drive(3'd0, 1'b0, 32'h0, 1'b1);

      // Throughput at occupancy one
      drive(3'd0, 1'b1, 32'h10, 1'b0);
      for (int i = 1; i <= 8; i++) drive(3'd0, 1'b1, 32'h10 + 32'(i), 1'b1);
      repeat (2) drive(3'd0, 1'b0, 32'h0, 1'b1);

      // Hold with one entry
      drive(3'd0, 1'b1, 32'h55, 1'b0);
      repeat (3) drive(3'b010, 1'b1, 32'h66, 1'b1);
      repeat (2) drive(3'd0, 1'b0, 32'h0, 1'b1);

      // Flush mid-operation, then first push after it
      drive(3'd0, 1'b1, 32'h21, 1'b0);
      drive(3'd0, 1'b1, 32'h22, 1'b0);
      drive(3'b011, 1'b1, 32'h77, 1'b1);
      drive(3'd0, 1'b1, 32'h88, 1'b0);
      repeat (2) drive(3'd0, 1'b0, 32'h0, 1'b1);

      // Empty buffer, push with downstream ready
      drive(3'd0, 1'b1, 32'h3C, 1'b1);
      repeat (2) drive(3'd0, 1'b0, 32'h0, 1'b1);

      // Random traffic, hold/flush codes and occasional reset
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         rst       = ($urandom_range(0, 99) != 0);
         hold_flag = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         din       = $urandom;
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (4) drive(3'd0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_reg_fifo.md
Name: pipe_reg_fifo

Overview:
Parametrised successor to the single-entry hold/flush pipeline register: a DEPTH-entry pipeline buffer between CPU stages. It has valid/ready handshakes on both sides and keeps the 3-bit hold/flush control bus. Flush and hold codes are parameter masks rather than hard-wired values. It sits between decoupled stages, for example fetch→decode, and absorbs downstream stalls without dropping instructions.

Parameters:
WIDTH, 32, payload width in bits
DEPTH, 2, number of entries; power of two, ≥2
RESET_VAL, 0, value driven on dout while empty and after reset/flush
FLUSH_CODES, 8'b0000_1010, bit k set → hold_flag==k flushes (codes 1, 3)
HOLD_CODES, 8'b0001_0100, bit k set → hold_flag==k freezes (codes 2, 4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
hold_flag  in  3  hold/flush control bus
in_valid  in  1  upstream payload valid
in_ready  out  1  buffer accepts push this cycle
din  in  WIDTH  upstream payload
out_valid  out  1  head entry available
out_ready  in  1  downstream accepts pop this cycle
dout  out  WIDTH  head entry payload
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Priority per cycle: reset > flush > hold > handshake.
- Reset (rst==0 at posedge): wr_ptr=0, rd_ptr=0, count=0. Storage contents are don't-care.
- Reset outputs: out_valid=0, in_ready=1, dout=RESET_VAL, count=0.
- Flush (FLUSH_CODES[hold_flag]==1): same state effect as reset at that edge. A push or pop presented in that cycle is discarded.
- During flush: in_ready=0 and out_valid=0 combinationally.
- Hold (HOLD_CODES[hold_flag]==1, not flush): pointers, count and storage are frozen.
- During hold: in_ready=0 and out_valid=0 combinationally. dout still shows the head entry, or RESET_VAL if empty.
- If a code is set in both masks, flush wins.
- Normal mode: in_ready = (count != DEPTH). A full buffer does not accept a push, even if a pop occurs in the same cycle.
- Normal mode: out_valid = (count != 0).
- Push = in_valid & in_ready. It writes din to mem[wr_ptr] and increments wr_ptr modulo DEPTH.
- Pop = out_valid & out_ready. It increments rd_ptr modulo DEPTH.
- Count: push only → +1; pop only → −1; push and pop together → unchanged.
- Push and pop in the same cycle is legal at any non-full, non-empty occupancy. On an empty buffer only the push takes effect.
- dout = mem[rd_ptr] when count≠0, else RESET_VAL (combinational read of head, show-ahead).
- Latency: a push at edge N gives out_valid=1 in cycle N+1, holding that payload. Minimum latency is 1 cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH−1→0.
- No overflow or underflow is possible, because push and pop are gated by ready/valid.
- Reset or flush mid-burst loses all in-flight entries. The first push afterwards lands at index 0.
- Elaboration fails if DEPTH<2 or DEPTH is not a power of two.

Optional Feature:
Macro PIPE_REG_FIFO_BYPASS_EN.
- Defined: when count==0, not hold, not flush, and in_valid==1, then out_valid=1 and dout=din combinationally.
- If out_ready==1 in that bypass cycle, the payload is consumed without being written; pointers and count are unchanged.
- If out_ready==0 in that bypass cycle, a normal push occurs.
- Bypass gives 0-cycle latency when empty.
- Not defined: no bypass path; minimum latency is 1 cycle as described above.

Test Plan:
- Reset: hold rst=0 two cycles with in_valid=1 → count=0, out_valid=0, dout=RESET_VAL, in_ready=1.
- Fill and drain, DEPTH=2, out_ready=0: push 0xA1, 0xB2 → count=2, in_ready=0. Then out_ready=1 → dout 0xA1 then 0xB2, count returns to 0.
- Throughput at count=1: in_valid=1 and out_ready=1 for 8 cycles with incrementing data → one pop per cycle, order preserved, count stays 1, pointers wrap correctly.
- Hold: with 1 entry 0x55, apply hold_flag=3'b010 for 3 cycles with in_valid=1 and out_ready=1 → in_ready=0, out_valid=0, count=1, dout=0x55. Release → 0x55 pops next cycle.
- Flush mid-operation: with 2 entries, apply hold_flag=3'b011 while pushing 0x77 → next cycle count=0 and dout=RESET_VAL. The next push of 0x88 appears at dout after 1 cycle.
- Bypass (macro defined): empty buffer, in_valid=1, din=0x3C, out_ready=1 → out_valid=1 and dout=0x3C in the same cycle, count stays 0. Macro undefined → out_valid=0 that cycle and 0x3C appears the next cycle.
